// File: rtl/pipelined_subtractor_pkg.sv
// Shared types and elaboration helpers for the segmented pipelined subtractor.
package pipelined_subtractor_pkg;

  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic int seg_count(input int width, input int seg_w);
    return (seg_w > 0) ? width / seg_w : 1;
  endfunction

  function automatic bit cfg_ok(input int width, input int seg_w);
    if (seg_w < 1 || width < 1) return 1'b0;
    return (width % seg_w) == 0;
  endfunction

endpackage

// File: rtl/pipelined_subtractor_sub_segment.sv
// Combinational SEG_W-bit ripple-borrow subtractor built from full-subtractor cells.
module sub_segment
  import pipelined_subtractor_pkg::*;
#(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_seg,
  input  logic [SEG_W-1:0] b_seg,
  input  logic             bin,
  output logic [SEG_W-1:0] diff_seg,
  output logic             bout
);

  logic [SEG_W:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < SEG_W; i++) begin : g_cell
    assign diff_seg[i] = a_seg[i] ^ b_seg[i] ^ brw[i];
    assign brw[i+1]    = (~a_seg[i] & b_seg[i]) | (~(a_seg[i] ^ b_seg[i]) & brw[i]);
  end

  assign bout = brw[SEG_W];

endmodule

// File: rtl/pipelined_subtractor.sv
// Streaming a - b - bin, one SEG_W-bit borrow segment per pipeline stage,
// with operand skew / result deskew so a whole beat emerges together.
module pipelined_subtractor
  import pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = seg_count(WIDTH, SEG_W);
  localparam int LAST   = STAGES - 1;

  if (!cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
    $fatal(1, "pipelined_subtractor: WIDTH must be a positive multiple of SEG_W >= 1");
  end

  logic                          adv, out_load;
  logic [STAGES-1:0]             vld_pipe_d, vld_pipe_q;
  logic [STAGES-1:0][SEG_W-1:0]  seg_a, seg_b, seg_diff, pre_diff, out_diff;
  logic [STAGES-1:0]             seg_bin, seg_bout;
  flags_t                        flags_d, flags_q;

  // Whole pipe moves together; the output slot only reloads when a real beat arrives.
  always_comb begin
    adv           = ~vld_pipe_q[LAST] | out_ready;
    vld_pipe_d    = '0;
    vld_pipe_d[0] = in_valid & adv;
    for (int k = 1; k < STAGES; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
    out_load      = adv & vld_pipe_d[LAST];
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    localparam int L = STAGES - j;

    if (j == 0) begin : g_head
      assign seg_a[j]   = a[SEG_W-1:0];
      assign seg_b[j]   = b[SEG_W-1:0];
      assign seg_bin[j] = bin;
    end else begin : g_skew
      // Segment j's operands wait j cycles for the borrow of segment j-1.
      logic [j-1:0][SEG_W-1:0] a_dl_d, a_dl_q, b_dl_d, b_dl_q;
      logic                    bin_d, bin_q;

      always_comb begin
        a_dl_d    = '0;
        b_dl_d    = '0;
        a_dl_d[0] = a[j*SEG_W +: SEG_W];
        b_dl_d[0] = b[j*SEG_W +: SEG_W];
        for (int i = 1; i < j; i++) begin
          a_dl_d[i] = a_dl_q[i-1];
          b_dl_d[i] = b_dl_q[i-1];
        end
        bin_d = seg_bout[j-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_dl_q <= '0;
          b_dl_q <= '0;
          bin_q  <= 1'b0;
        end else if (adv) begin
          a_dl_q <= a_dl_d;
          b_dl_q <= b_dl_d;
          bin_q  <= bin_d;
        end
      end

      assign seg_a[j]   = a_dl_q[j-1];
      assign seg_b[j]   = b_dl_q[j-1];
      assign seg_bin[j] = bin_q;
    end

    sub_segment #(.SEG_W(SEG_W)) u_sub (
      .a_seg    (seg_a[j]),
      .b_seg    (seg_b[j]),
      .bin      (seg_bin[j]),
      .diff_seg (seg_diff[j]),
      .bout     (seg_bout[j])
    );

    // Deskew: finished segment rides along until the last stage; top entry is the output.
    logic [L-1:0][SEG_W-1:0] dd_d, dd_q;

    always_comb begin
      dd_d    = '0;
      dd_d[0] = seg_diff[j];
      for (int i = 1; i < L; i++) dd_d[i] = dd_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dd_q <= '0;
      end else begin
        for (int i = 0; i < L; i++) begin
          if ((i == L-1) ? out_load : adv) dd_q[i] <= dd_d[i];
        end
      end
    end

    assign pre_diff[j] = dd_d[L-1];
    assign out_diff[j] = dd_q[L-1];
  end

  // MSB segment operands arrive at the last stage, so their sign bits are on hand here.
  always_comb begin
    flags_d.bout = seg_bout[LAST];
    flags_d.zero = (pre_diff == '0);
    flags_d.ovf  = (seg_a[LAST][SEG_W-1] != seg_b[LAST][SEG_W-1]) &&
                   (pre_diff[LAST][SEG_W-1] != seg_a[LAST][SEG_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      flags_q    <= '0;
    end else begin
      if (adv)      vld_pipe_q <= vld_pipe_d;
      if (out_load) flags_q    <= flags_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[LAST];
  assign diff      = out_diff;
  assign bout      = flags_q.bout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed table, streaming, stall, random and mid-stream reset checks for pipelined_subtractor.
module tb_pipelined_subtractor;

  localparam int W      = 16;
  localparam int SEG_W  = 4;
  localparam int STAGES = W / SEG_W;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, bout, ovf, zero;
  logic [W-1:0] diff;

  pipelined_subtractor #(.WIDTH(W), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  res_t expq[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; bit W of the wide result is the borrow.
  function automatic res_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    logic [W:0] t;
    res_t       r;
    t      = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (ia[W-1] != ib[W-1]) && (t[W-1] != ia[W-1]);
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                              input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
    vec_t v;
    v.a = ia; v.b = ib; v.bin = ibin;
    v.exp.diff = d; v.exp.bout = bo; v.exp.ovf = ov; v.exp.zero = z;
    return v;
  endfunction

  // Drive one cycle's inputs at the negedge, sample, and score any delivered beat.
  task automatic tick(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                      input logic ordy, output logic dlv, output res_t got);
    res_t e;
    in_valid = v; a = ia; b = ib; bin = ibin; out_ready = ordy;
    #1;
    got.diff = diff; got.bout = bout; got.ovf = ovf; got.zero = zero;
    dlv = out_valid & ordy;
    if (v && in_ready) expq.push_back(model(ia, ib, ibin));
    if (dlv) begin
      if (expq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_beat: got diff %h, expected no beat", diff);
      end else begin
        e = expq.pop_front();
        chkw("q_diff", diff, e.diff);
        chk1("q_bout", bout, e.bout);
        chk1("q_ovf",  ovf,  e.ovf);
        chk1("q_zero", zero, e.zero);
      end
    end
  endtask

  task automatic one_beat(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          output res_t got, output int lat);
    logic dd;
    res_t gg;
    lat = -1;
    got = '0;
    tick(1'b1, ia, ib, ibin, 1'b1, dd, gg);
    @(negedge clk);
    for (int k = 1; k <= STAGES + 8 && lat < 0; k++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, dd, gg);
      if (dd) begin
        lat = k;
        got = gg;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_chk++; n_fail++;
      $display("FAIL beat_timeout: got no result, expected one within %0d cycles", STAGES + 8);
    end
  endtask

  vec_t         tv[10];
  res_t         g, snap;
  logic         d, ordy, v;
  logic [W-1:0] ra, rb;
  logic         rbin;
  int           lat, dcnt, sent, stall;
  bit           post_done;

  initial begin
    tv[0] = mk(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    tv[1] = mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tv[2] = mk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    tv[3] = mk(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tv[4] = mk(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    tv[5] = mk(16'h00F0, 16'h000F, 1'b1, 16'h00E0, 1'b0, 1'b0, 1'b0);
    tv[6] = mk(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tv[7] = mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    tv[8] = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tv[9] = mk(16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0);

    // Reset state
    @(negedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_diff", diff, '0);
    chk1("rst_bout", bout, 1'b0);
    chk1("rst_ovf",  ovf,  1'b0);
    chk1("rst_zero", zero, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors, one beat at a time
    for (int i = 0; i < 10; i++) begin
      one_beat(tv[i].a, tv[i].b, tv[i].bin, g, lat);
      chki("tv_latency", lat, STAGES);
      chkw("tv_diff", g.diff, tv[i].exp.diff);
      chk1("tv_bout", g.bout, tv[i].exp.bout);
      chk1("tv_ovf",  g.ovf,  tv[i].exp.ovf);
      chk1("tv_zero", g.zero, tv[i].exp.zero);
    end

    // 8 back-to-back beats: results on 8 consecutive cycles after the pipe latency
    dcnt = 0;
    for (int k = 0; k < STAGES + 16 && dcnt < 8; k++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      tick(k < 8, ra, rb, rbin, 1'b1, d, g);
      if (k < 8) chk1("b2b_in_ready", in_ready, 1'b1);
      if (d) begin
        chki("b2b_slot", k, STAGES + dcnt);
        dcnt++;
      end
      @(negedge clk);
    end
    chki("b2b_count", dcnt, 8);

    // 6 beats with a 3-cycle downstream stall after the second result
    dcnt = 0; sent = 0; stall = 0; post_done = 1'b0; snap = '0;
    for (int k = 0; k < 60 && dcnt < 6; k++) begin
      ordy = !(dcnt >= 2 && stall < 3);
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      tick(sent < 6, ra, rb, rbin, ordy, d, g);
      if (sent < 6 && in_ready) sent++;
      if (!ordy) begin
        chk1("stall_in_ready", in_ready, 1'b0);
        chk1("stall_out_valid", out_valid, 1'b1);
        if (stall == 0) snap = g;
        else begin
          chkw("stall_diff", g.diff, snap.diff);
          chk1("stall_bout", g.bout, snap.bout);
          chk1("stall_ovf",  g.ovf,  snap.ovf);
          chk1("stall_zero", g.zero, snap.zero);
        end
        stall++;
      end else begin
        chk1("run_in_ready", in_ready, 1'b1);
        if (stall == 3 && !post_done) begin
          chkw("post_stall_diff", g.diff, snap.diff);
          post_done = 1'b1;
        end
      end
      if (d) dcnt++;
      @(negedge clk);
    end
    chki("stall_delivered", dcnt, 6);
    chki("stall_stalls", stall, 3);
    chki("stall_q_empty", expq.size(), 0);

    // Random traffic with random backpressure, then drain
    for (int k = 0; k < 400; k++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      tick(v, ra, rb, rbin, ordy, d, g);
      if (ordy) chk1("rand_in_ready", in_ready, 1'b1);
      @(negedge clk);
    end
    for (int k = 0; k < STAGES + 20 && expq.size() != 0; k++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, d, g);
      @(negedge clk);
    end
    chki("rand_drain_q_empty", expq.size(), 0);

    // Fill the pipe under backpressure, then reset mid-stream
    for (int k = 0; k < 20 && !out_valid; k++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      tick(1'b1, ra, rb, rbin, 1'b0, d, g);
      @(negedge clk);
    end
    chk1("fill_out_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_out_valid", out_valid, 1'b0);
    chkw("async_rst_diff", diff, '0);
    chk1("async_rst_bout", bout, 1'b0);
    chk1("async_rst_ovf",  ovf,  1'b0);
    chk1("async_rst_zero", zero, 1'b0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < STAGES + 6; k++) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, d, g);
      chk1("no_stale_beat", out_valid, 1'b0);
      @(negedge clk);
    end
    one_beat(16'hABCD, 16'h1234, 1'b1, g, lat);
    chki("post_rst_latency", lat, STAGES);
    chkw("post_rst_diff", g.diff, 16'h9998);
    chk1("post_rst_bout", g.bout, 1'b0);
    chk1("post_rst_ovf",  g.ovf,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
Parametrised N-bit subtractor computing diff = a - b - bin. The borrow chain is split into SEG_W-bit segments, one pipeline stage per segment, so wide operands meet timing at one segment's ripple depth. Uses a valid/ready streaming handshake with full backpressure. Returns borrow-out, signed-overflow and zero flags. It is the datapath building block for ALU and counter logic that needs subtraction wider than a single full-subtractor cell.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG_W.
SEG_W, 4, bits resolved per pipeline stage.
STAGES, WIDTH/SEG_W (derived localparam), pipeline depth and latency in cycles.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
bin  in  1  borrow-in
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
bout  out  1  borrow-out; 1 when unsigned a < b + bin
ovf  out  1  signed (two's-complement) overflow
zero  out  1  diff == 0

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits clear. out_valid=0, diff=0, bout=0, ovf=0, zero=0. in_ready reflects the empty pipe, so it is 1 once rst_n is high.
- Advance enable: adv = ~out_valid | out_ready. The whole pipe shifts on adv. in_ready = adv, which is combinational from out_ready.
- A beat is accepted on in_valid & in_ready. Bubbles travel as valid=0 slots. The pipe does not compact bubbles internally, so throughput is 1 beat/cycle when out_ready is held at 1.
- Stage k (0..STAGES-1) subtracts segment k, bits [k*SEG_W +: SEG_W], using the borrow registered by stage k-1. Stage 0 uses bin.
- Skew and deskew:
  - Upper operand segments are carried forward in registers until their stage.
  - Completed lower diff segments are carried forward until the last stage.
  - All WIDTH diff bits of a beat therefore appear together.
- Latency: a beat accepted at edge t appears on outputs after edge t+STAGES-1 when there is no stall (visible STAGES cycles after acceptance).
- Flags are computed in the last stage and registered with diff:
  - bout = borrow out of the MSB segment.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]). a[MSB] and b[MSB] are carried forward to the last stage. bin does not enter the ovf formula beyond its effect on diff.
- Stall: while out_valid=1 and out_ready=0:
  - All stage registers hold.
  - diff, bout, ovf and zero stay stable.
  - in_ready=0, so in_valid is ignored.
- Output hold: outputs change only on a transfer or when a new beat arrives into an empty output slot. With out_valid=0, diff and the flags hold their last values; the bench must not check them.
- Wrap-around: diff is always modulo 2^WIDTH, e.g. 0 - 1 gives all ones with bout=1.
- Simultaneous accept and deliver in the same cycle is legal, with no bubble inserted.
- Reset mid-stream: all in-flight beats are discarded and none is emitted after reset release.
- Elaboration: WIDTH % SEG_W != 0 or SEG_W < 1 is an elaboration error, reported via a generate-time fatal check.

Decomposition:
- No shared package needed; STAGES is a local derived constant. If a common arith package exists, a shared flag-bundle struct {bout, ovf, zero} may live there.
- One sub-module: sub_segment. It is a combinational SEG_W-bit ripple borrow subtractor (a_seg, b_seg, bin → diff_seg, bout) built from per-bit full-subtractor cells and instantiated STAGES times by generate.
- All registers live in pipelined_subtractor.

Test Plan:
(WIDTH=16, SEG_W=4, latency 4; also rerun the regression with WIDTH=32, SEG_W=8.)
- a=0x1234, b=0x0034, bin=0 → diff=0x1200, bout=0, ovf=0, zero=0, out_valid 4 cycles after accept.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0. Then a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1.
- a=0x0005, b=0x0005, bin=0 → zero=1. Then a=0x0005, b=0x0004, bin=1 → diff=0x0000, zero=1, bout=0. Then a=0x00F0, b=0x000F, bin=1 → diff=0x00E0 (borrow crosses a segment boundary).
- Stream 8 back-to-back beats with out_ready=1 → 8 results on 8 consecutive cycles, in order, each matching the reference model.
- Stream 6 beats, drop out_ready for 3 cycles mid-stream → in_ready=0 exactly those cycles, outputs stable while stalled, all 6 results delivered once, in order.
- Assert rst_n=0 with 3 beats in flight → out_valid=0 immediately (async). After release, no stale beat appears and the next beat's result is correct.
